instr_fetch_queue: RTL and testbench
====================================

Name: instr_fetch_queue

Overview:
- Sits directly downstream of the fetch unit's program counter.
- Turns each valid PC into a request on the instruction-memory request/grant/rvalid bus and tracks in-flight requests.
- Buffers returned instruction words in a small FIFO and presents them to decode with a valid/ready handshake.
- Discards queued and in-flight fetches on a taken branch/jump redirect.

Parameters:
DEPTH, 4, instruction FIFO entries (power of two, ≥2)
MAX_OUT, 2, maximum outstanding memory requests (≤DEPTH)

Ports:
clk_i  in  1  clock, rising edge
PCrst_i  in  1  asynchronous active-low reset
pc_i  in  32  PC from fetch unit
pc_valid_i  in  1  pc_i is a fetch candidate
pc_ready_o  out  1  pc_i consumed this cycle; fetch unit must hold PC when low
flush_i  in  1  redirect pulse (BE/UJE/JALRE taken)
imem_req_o  out  1  memory request
imem_addr_o  out  32  word-aligned request address
imem_gnt_i  in  1  request accepted
imem_rvalid_i  in  1  response valid (in order, ≥1 cycle after grant)
imem_rdata_i  in  32  instruction word
imem_err_i  in  1  bus error, qualified by rvalid
instr_valid_o  out  1  FIFO head valid
instr_o  out  32  head instruction
instr_pc_o  out  32  head PC
instr_err_o  out  1  head fetch error
instr_ready_i  in  1  decode accepts head
count_o  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:

Reset:
- PCrst_i low clears FIFO pointers, count_o, the outstanding counter and the discard counter immediately.
- All outputs read 0 during reset.
- Reset mid-transaction forgets in-flight requests. The memory side is reset by the same signal.

Credit and issue:
- credit = (count + outstanding) < DEPTH and outstanding < MAX_OUT.
- imem_req_o = pc_valid_i & credit & ~flush_i (combinational).
- imem_addr_o = {pc_i[31:2],2'b00}.
- pc_ready_o = imem_req_o & imem_gnt_i.

Pending-address FIFO:
- MAX_OUT entries.
- Pushes pc_i on grant; pops on rvalid.
- outstanding = pending occupancy: +1 on grant, −1 on rvalid, unchanged when both occur.

Response:
- On imem_rvalid_i with discard==0, push {rdata, pending-head PC, err} into the instruction FIFO at the clock edge.
- The entry is visible at the head the next cycle, so minimum latency is grant to instr_valid_o = 2 cycles.
- If discard>0, drop the response and decrement discard.

Output:
- instr_valid_o = (count!=0).
- instr_o, instr_pc_o and instr_err_o are the FIFO head, stable while valid & ~ready.
- Pop on instr_valid_o & instr_ready_i.
- Push and pop in the same cycle leaves count unchanged.
- Credit guarantees no overflow. A push when full is illegal and asserted in simulation.

Flush (flush_i=1 at an edge):
- count, pointers and pending FIFO clear.
- discard <= outstanding − (imem_rvalid_i ? 1 : 0); the response arriving in the flush cycle is also dropped.
- No request issues in the flush cycle.
- A pop in the flush cycle is ignored.
- The new PC may issue from the next cycle, while discard>0. New responses are kept only after discard reaches 0 (in-order bus).

Error responses:
- Queued like normal entries with instr_err_o=1; the queue takes no other action.

Counters:
- Saturation is impossible by construction.
- Pointers wrap modulo DEPTH.

Test Plan:
- Reset, pc_valid_i=1 at pc_i=0x0, gnt=1, rvalid one cycle later with 0x00000013 → instr_valid_o=1 two cycles after grant; instr_o=0x00000013, instr_pc_o=0x0, count_o=1.
- Decode stalled (ready=0), continuous grants/responses with PCs 0x0, 0x4, 0x8, … → exactly 4 entries, imem_req_o=0 thereafter, pc_ready_o=0; release ready → entries drain in order 0x0, 0x4, 0x8, 0xC.
- Two requests outstanding (0x10, 0x14), flush_i pulse with next pc_i=0x100 → both old responses dropped; first delivered entry has instr_pc_o=0x100.
- Flush coinciding with rvalid for 0x20 and one more outstanding → discard=1; both old responses dropped, count_o=0.
- rvalid with imem_err_i=1 for PC 0x40 → entry instr_err_o=1, instr_pc_o=0x40; following entry instr_err_o=0.
- Assert PCrst_i low mid-stream with 3 queued and 1 outstanding → count_o=0 and instr_valid_o=0 asynchronously; after release, first request uses the current pc_i.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - PC-to-imem request issue, in-flight tracking and instruction FIFO
//
// Ports:
//   clk_i, PCrst_i                    clock (rising edge), asynchronous active-low reset
//   pc_i, pc_valid_i, pc_ready_o      PC candidate from fetch; ready means consumed this cycle
//   flush_i                           redirect pulse, discards queued and in-flight fetches
//   imem_req_o, imem_addr_o           memory request and word-aligned address
//   imem_gnt_i                        request accepted
//   imem_rvalid_i, imem_rdata_i,
//   imem_err_i                        in-order response, data and bus error
//   instr_valid_o, instr_o,
//   instr_pc_o, instr_err_o,
//   instr_ready_i                     FIFO head towards decode with valid/ready handshake
//   count_o                           FIFO occupancy
module instr_fetch_queue #(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic                     clk_i,
    input  logic                     PCrst_i,
    input  logic [31:0]              pc_i,
    input  logic                     pc_valid_i,
    output logic                     pc_ready_o,
    input  logic                     flush_i,
    output logic                     imem_req_o,
    output logic [31:0]              imem_addr_o,
    input  logic                     imem_gnt_i,
    input  logic                     imem_rvalid_i,
    input  logic [31:0]              imem_rdata_i,
    input  logic                     imem_err_i,
    output logic                     instr_valid_o,
    output logic [31:0]              instr_o,
    output logic [31:0]              instr_pc_o,
    output logic                     instr_err_o,
    input  logic                     instr_ready_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int OW = $clog2(MAX_OUT + 1);
    // Discard headroom: back-to-back redirects while old responses are still
    // draining add up, so the counter is wider than one MAX_OUT window.
    localparam int DW = OW + 4;

    logic [31:0]   data_q [DEPTH];
    logic [31:0]   ipc_q  [DEPTH];
    logic          err_q  [DEPTH];
    logic [31:0]   pend_q [MAX_OUT];

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [PW-1:0] pwr_q, prd_q;
    logic [OW-1:0] out_q;
    logic [DW-1:0] discard_q;

    logic credit, grant, rsp_keep, push, pop;

    function automatic logic [PW-1:0] pinc(input logic [PW-1:0] p);
        return (32'(p) == MAX_OUT - 1) ? '0 : p + 1'b1;
    endfunction

    assign credit   = (32'(count_q) + 32'(out_q) < DEPTH) && (32'(out_q) < MAX_OUT);
    assign imem_req_o  = PCrst_i & pc_valid_i & credit & ~flush_i;
    assign imem_addr_o = imem_req_o ? {pc_i[31:2], 2'b00} : 32'h0;
    assign grant       = imem_req_o & imem_gnt_i;
    assign pc_ready_o  = grant;

    // Responses belonging to pre-redirect requests are swallowed until discard drains.
    assign rsp_keep = imem_rvalid_i & ~flush_i & (discard_q == '0);
    assign push     = rsp_keep;
    assign pop      = instr_valid_o & instr_ready_i & ~flush_i;

    assign instr_valid_o = (count_q != '0);
    assign instr_o       = instr_valid_o ? data_q[rd_ptr_q] : 32'h0;
    assign instr_pc_o    = instr_valid_o ? ipc_q[rd_ptr_q]  : 32'h0;
    assign instr_err_o   = instr_valid_o ? err_q[rd_ptr_q]  : 1'b0;
    assign count_o       = count_q;

    always_ff @(posedge clk_i or negedge PCrst_i) begin
        if (!PCrst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pwr_q     <= '0;
            prd_q     <= '0;
            out_q     <= '0;
            discard_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pwr_q     <= '0;
            prd_q     <= '0;
            out_q     <= '0;
            // The response landing in the flush cycle is one of the dropped ones.
            discard_q <= discard_q + DW'(out_q) - DW'(imem_rvalid_i);
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (grant)    pwr_q <= pinc(pwr_q);
            if (rsp_keep) prd_q <= pinc(prd_q);
            case ({grant, rsp_keep})
                2'b10:   out_q <= out_q + 1'b1;
                2'b01:   out_q <= out_q - 1'b1;
                default: out_q <= out_q;
            endcase
            if (imem_rvalid_i && discard_q != '0) discard_q <= discard_q - 1'b1;
        end
    end

    // Storage needs no reset: occupancy counters gate every read.
    always_ff @(posedge clk_i) begin
        if (grant) pend_q[pwr_q] <= pc_i;
        if (push) begin
            data_q[wr_ptr_q] <= imem_rdata_i;
            ipc_q[wr_ptr_q]  <= pend_q[prd_q];
            err_q[wr_ptr_q]  <= imem_err_i;
        end
    end

    no_overflow: assert property (@(posedge clk_i) disable iff (!PCrst_i)
        !(push && !pop && count_q == CW'(DEPTH)));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - directed self-checking bench for instr_fetch_queue
module tb_instr_fetch_queue;

    logic        clk_i = 1'b0;
    logic        PCrst_i;
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic        pc_ready_o;
    logic        flush_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        imem_err_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_err_o;
    logic        instr_ready_i;
    logic [2:0]  count_o;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] K = 32'hA5A5_0000;

    instr_fetch_queue #(.DEPTH(4), .MAX_OUT(2)) dut (
        .clk_i(clk_i), .PCrst_i(PCrst_i),
        .pc_i(pc_i), .pc_valid_i(pc_valid_i), .pc_ready_o(pc_ready_o),
        .flush_i(flush_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .imem_err_i(imem_err_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .instr_err_o(instr_err_o), .instr_ready_i(instr_ready_i), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Request side: PC valid + grant together.
    task automatic req(input logic v, input logic [31:0] pc, input logic g);
        pc_valid_i = v;
        pc_i       = pc;
        imem_gnt_i = g;
    endtask

    task automatic rsp(input logic v, input logic [31:0] d, input logic e);
        imem_rvalid_i = v;
        imem_rdata_i  = d;
        imem_err_i    = e;
    endtask

    logic        fire;
    logic [31:0] fpc;
    logic [31:0] npc;

    initial begin
        PCrst_i       = 1'b0;
        flush_i       = 1'b0;
        instr_ready_i = 1'b0;
        req(1'b1, 32'h0, 1'b1);
        rsp(1'b0, 32'h0, 1'b0);

        // Reset: outputs gated to zero even with a valid PC presented.
        #2;
        check("rst_req",   32'(imem_req_o),    32'h0);
        check("rst_valid", 32'(instr_valid_o), 32'h0);
        check("rst_count", 32'(count_o),       32'h0);
        check("rst_pcrdy", 32'(pc_ready_o),    32'h0);
        @(posedge clk_i);
        #1;
        PCrst_i = 1'b1;

        // Basic fetch: grant at edge A, response at edge B, head visible after B.
        req(1'b1, 32'h0, 1'b1);
        #1;
        check("t1_req",   32'(imem_req_o), 32'h1);
        check("t1_addr",  imem_addr_o,     32'h0);
        check("t1_pcrdy", 32'(pc_ready_o), 32'h1);
        step();
        req(1'b0, 32'h0, 1'b0);
        rsp(1'b1, 32'h0000_0013, 1'b0);
        #1;
        check("t1_early_valid", 32'(instr_valid_o), 32'h0);
        step();
        rsp(1'b0, 32'h0, 1'b0);
        check("t1_valid", 32'(instr_valid_o), 32'h1);
        check("t1_instr", instr_o,            32'h0000_0013);
        check("t1_pc",    instr_pc_o,         32'h0);
        check("t1_count", 32'(count_o),       32'h1);
        instr_ready_i = 1'b1;
        step();
        instr_ready_i = 1'b0;
        check("t1_drained", 32'(count_o), 32'h0);

        // Stalled decode with an always-granting, 1-cycle-latency memory.
        npc = 32'h0;
        req(1'b1, npc, 1'b1);
        for (int c = 0; c < 8; c++) begin
            pc_i = npc;
            #1;
            fire = imem_req_o & imem_gnt_i;
            fpc  = pc_i;
            step();
            if (fire) begin
                rsp(1'b1, fpc ^ K, 1'b0);
                npc = npc + 32'h4;
            end else begin
                rsp(1'b0, 32'h0, 1'b0);
            end
        end
        pc_i = npc;
        #1;
        check("t2_count", 32'(count_o),    32'h4);
        check("t2_req",   32'(imem_req_o), 32'h0);
        check("t2_pcrdy", 32'(pc_ready_o), 32'h0);
        check("t2_npc",   npc,             32'h10);
        req(1'b0, 32'h0, 1'b0);
        instr_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t2_drain_pc",    instr_pc_o, 32'(i * 4));
            check("t2_drain_instr", instr_o,    32'(i * 4) ^ K);
            step();
        end
        instr_ready_i = 1'b0;
        check("t2_empty", 32'(count_o), 32'h0);

        // Flush with two outstanding requests.
        req(1'b1, 32'h10, 1'b1);
        step();
        req(1'b1, 32'h14, 1'b1);
        step();
        req(1'b1, 32'h100, 1'b1);
        flush_i = 1'b1;
        #1;
        check("t3_flush_req",   32'(imem_req_o), 32'h0);
        check("t3_flush_pcrdy", 32'(pc_ready_o), 32'h0);
        step();
        flush_i = 1'b0;
        #1;
        check("t3_req_after", 32'(imem_req_o), 32'h1);
        check("t3_addr",      imem_addr_o,     32'h100);
        step();
        req(1'b0, 32'h0, 1'b0);
        rsp(1'b1, 32'hDEAD_0010, 1'b0);
        step();
        rsp(1'b1, 32'hDEAD_0014, 1'b0);
        step();
        rsp(1'b0, 32'h0, 1'b0);
        check("t3_dropped", 32'(count_o), 32'h0);
        rsp(1'b1, 32'h0000_1111, 1'b0);
        step();
        rsp(1'b0, 32'h0, 1'b0);
        check("t3_valid", 32'(instr_valid_o), 32'h1);
        check("t3_pc",    instr_pc_o,         32'h100);
        check("t3_instr", instr_o,            32'h0000_1111);
        instr_ready_i = 1'b1;
        step();
        instr_ready_i = 1'b0;

        // Flush coinciding with the response for 0x20, 0x24 still outstanding.
        req(1'b1, 32'h20, 1'b1);
        step();
        req(1'b1, 32'h24, 1'b1);
        step();
        req(1'b0, 32'h0, 1'b0);
        flush_i = 1'b1;
        rsp(1'b1, 32'hDEAD_0020, 1'b0);
        step();
        flush_i = 1'b0;
        rsp(1'b1, 32'hDEAD_0024, 1'b0);
        step();
        rsp(1'b0, 32'h0, 1'b0);
        check("t4_count", 32'(count_o),       32'h0);
        check("t4_valid", 32'(instr_valid_o), 32'h0);
        req(1'b1, 32'h30, 1'b1);
        step();
        req(1'b0, 32'h0, 1'b0);
        rsp(1'b1, 32'h0000_3030, 1'b0);
        step();
        rsp(1'b0, 32'h0, 1'b0);
        check("t4_kept_count", 32'(count_o), 32'h1);
        check("t4_kept_pc",    instr_pc_o,   32'h30);
        instr_ready_i = 1'b1;
        step();
        instr_ready_i = 1'b0;

        // Error response followed by a clean one.
        req(1'b1, 32'h40, 1'b1);
        step();
        req(1'b1, 32'h44, 1'b1);
        rsp(1'b1, 32'h0000_4040, 1'b1);
        step();
        req(1'b0, 32'h0, 1'b0);
        rsp(1'b1, 32'h0000_4444, 1'b0);
        step();
        rsp(1'b0, 32'h0, 1'b0);
        check("t5_err",   32'(instr_err_o), 32'h1);
        check("t5_pc",    instr_pc_o,       32'h40);
        instr_ready_i = 1'b1;
        step();
        check("t5_err2",  32'(instr_err_o), 32'h0);
        check("t5_pc2",   instr_pc_o,       32'h44);
        step();
        instr_ready_i = 1'b0;
        check("t5_empty", 32'(count_o), 32'h0);

        // Reset mid-stream: 3 queued, 1 outstanding.
        req(1'b1, 32'h50, 1'b1);
        step();
        req(1'b1, 32'h54, 1'b1);
        rsp(1'b1, 32'h0000_5050, 1'b0);
        step();
        req(1'b1, 32'h58, 1'b1);
        rsp(1'b1, 32'h0000_5454, 1'b0);
        step();
        req(1'b1, 32'h5C, 1'b1);
        rsp(1'b1, 32'h0000_5858, 1'b0);
        step();
        req(1'b0, 32'h0, 1'b0);
        rsp(1'b0, 32'h0, 1'b0);
        check("t6_pre_count", 32'(count_o), 32'h3);
        #1;
        PCrst_i = 1'b0;
        #1;
        check("t6_rst_count", 32'(count_o),       32'h0);
        check("t6_rst_valid", 32'(instr_valid_o), 32'h0);
        step();
        PCrst_i = 1'b1;
        req(1'b1, 32'h200, 1'b1);
        #1;
        check("t6_req",  32'(imem_req_o), 32'h1);
        check("t6_addr", imem_addr_o,     32'h200);
        step();
        req(1'b0, 32'h0, 1'b0);
        rsp(1'b1, 32'h0000_2222, 1'b0);
        step();
        rsp(1'b0, 32'h0, 1'b0);
        check("t6_pc",    instr_pc_o,   32'h200);
        check("t6_instr", instr_o,      32'h0000_2222);
        check("t6_count", 32'(count_o), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
